// File: rtl/spi_pkg.sv
// Shared SPI definitions: state encoding, default geometry and counter sizing.
// Used by spi_tx, spi_clk_tick and the SPI microphone receiver.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } spi_state_e;

    localparam int unsigned SPI_DATA_W  = 16;
    localparam int unsigned SPI_CLK_DIV = 6;

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int unsigned spi_cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// Half-period tick generator: one-cycle tick every CLK_DIV cycles while enabled.
// The count is held at zero whenever en_i is low.
module spi_clk_tick
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
    input  logic CLK,
    input  logic RST,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned    CW   = spi_cnt_w(CLK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d  = '0;
            tick_o = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/spi_tx.sv
// SPI mode-0 master transmitter (SCLK, nCS, SDATA), MSB first by default.
// Define SPI_TX_LSB_FIRST_EN to send LSB first with identical timing.
module spi_tx
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W  = SPI_DATA_W,
    parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] DATA,
    input  logic              START,
    output logic              READY,
    output logic              DONE,
    output logic              SCLK,
    output logic              nCS,
    output logic              SDATA
);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("spi_tx: CLK_DIV must be >= 2");
    end
    if (DATA_W < 2 || DATA_W > 32) begin : g_bad_data_w
        $error("spi_tx: DATA_W must be within 2..32");
    end

    localparam int unsigned    BW       = spi_cnt_w(DATA_W);
    localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_W - 1);

`ifdef SPI_TX_LSB_FIRST_EN
    localparam int unsigned OUT_IDX = 0;
`else
    localparam int unsigned OUT_IDX = DATA_W - 1;
`endif

    spi_state_e        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d, shifted;
    logic [BW-1:0]     bit_q, bit_d;
    logic              sclk_q, sclk_d;
    logic              ncs_q, ncs_d;
    logic              sdata_q, sdata_d;
    logic              done_q, done_d;
    logic              tick_en, tick;

    assign tick_en = (state_q != IDLE);

    spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .CLK    (CLK),
        .RST    (RST),
        .en_i   (tick_en),
        .tick_o (tick)
    );

`ifdef SPI_TX_LSB_FIRST_EN
    assign shifted = shift_q >> 1;
`else
    assign shifted = shift_q << 1;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        ncs_d   = ncs_q;
        sdata_d = sdata_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // The divider is already held at zero while idle.
                if (START) begin
                    shift_d = DATA;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                    ncs_d   = 1'b0;
                    sdata_d = DATA[OUT_IDX];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_q == BIT_LAST) begin
                        sclk_d  = 1'b0;
                        ncs_d   = 1'b1;
                        sdata_d = 1'b0;
                        state_d = HOLD;
                    end else begin
                        sclk_d  = 1'b0;
                        shift_d = shifted;
                        sdata_d = shifted[OUT_IDX];
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            ncs_q   <= 1'b1;
            sdata_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            ncs_q   <= ncs_d;
            sdata_q <= sdata_d;
            done_q  <= done_d;
        end
    end

    assign READY = (state_q == IDLE);
    assign DONE  = done_q;
    assign SCLK  = sclk_q;
    assign nCS   = ncs_q;
    assign SDATA = sdata_q;

endmodule

// File: tb/tb_spi_tx.sv
// Directed bench for spi_tx: default geometry DUT plus an 8-bit, CLK_DIV=2 DUT.
// Words are pushed to a scoreboard at acceptance and compared when nCS deasserts.
module tb_spi_tx;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] DATA = '0;
    logic        START = 1'b0;
    logic        READY, DONE, SCLK, nCS, SDATA;
    logic [7:0]  DATA8 = '0;
    logic        START8 = 1'b0;
    logic        READY8, DONE8, SCLK8, nCS8, SDATA8;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    spi_tx dut (
        .CLK(CLK), .RST(RST), .DATA(DATA), .START(START), .READY(READY),
        .DONE(DONE), .SCLK(SCLK), .nCS(nCS), .SDATA(SDATA)
    );

    spi_tx #(.DATA_W(8), .CLK_DIV(2)) dut8 (
        .CLK(CLK), .RST(RST), .DATA(DATA8), .START(START8), .READY(READY8),
        .DONE(DONE8), .SCLK(SCLK8), .nCS(nCS8), .SDATA(SDATA8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Word as the receiver assembles it (first bit on the wire lands in the MSB).
    function automatic logic [31:0] exp_word(input logic [31:0] d, input int unsigned w);
        logic [31:0] r;
        r = d;
`ifdef SPI_TX_LSB_FIRST_EN
        r = '0;
        for (int unsigned i = 0; i < w; i++) r[i] = d[w-1-i];
`endif
        return r;
    endfunction

    function automatic logic [31:0] first_bit(input logic [31:0] d, input int unsigned w);
`ifdef SPI_TX_LSB_FIRST_EN
        return 32'(d[0]);
`else
        return 32'(d[w-1]);
`endif
    endfunction

    logic [31:0] q[$];
    logic [31:0] q8[$];

    // Scoreboard monitor, default DUT
    logic [31:0] ma_word = '0;
    int          ma_n = 0;
    logic        ma_sclk = 1'b0, ma_ncs = 1'b1, ma_discard = 1'b0;
    logic [31:0] ma_exp;
    always @(negedge CLK) begin
        if (SCLK && !ma_sclk) begin ma_word = {ma_word[30:0], SDATA}; ma_n++; end
        if (nCS && !ma_ncs) begin
            if (ma_discard || RST) ma_discard = 1'b0;
            else if (q.size() == 0) chk("sb_unexpected_word", ma_word, 32'hFFFF_FFFF);
            else begin
                ma_exp = q.pop_front();
                chk("sb_word", ma_word, ma_exp);
                chk("sb_bits", 32'(ma_n), 32'd16);
            end
            ma_word = '0; ma_n = 0;
        end
        ma_sclk = SCLK; ma_ncs = nCS;
    end

    // Scoreboard monitor, 8-bit DUT
    logic [31:0] mb_word = '0;
    int          mb_n = 0;
    logic        mb_sclk = 1'b0, mb_ncs = 1'b1;
    logic [31:0] mb_exp;
    always @(negedge CLK) begin
        if (SCLK8 && !mb_sclk) begin mb_word = {mb_word[30:0], SDATA8}; mb_n++; end
        if (nCS8 && !mb_ncs) begin
            if (RST) ;
            else if (q8.size() == 0) chk("sb8_unexpected_word", mb_word, 32'hFFFF_FFFF);
            else begin
                mb_exp = q8.pop_front();
                chk("sb8_word", mb_word, mb_exp);
                chk("sb8_bits", 32'(mb_n), 32'd8);
            end
            mb_word = '0; mb_n = 0;
        end
        mb_sclk = SCLK8; mb_ncs = nCS8;
    end

    // Event log for the default DUT, cycle numbers relative to acceptance
    int   cyc_rel, ncs_fall_n, ncs_fall_last, ncs_rise_first;
    int   rise_n, first_rise, last_rise, done_n, done_first, ready_bad;
    logic ready_at_done, p_ncs, p_sclk;

    task automatic clr_obs();
        cyc_rel = 0; ncs_fall_n = 0; ncs_fall_last = -1; ncs_rise_first = -1;
        rise_n = 0; first_rise = -1; last_rise = -1; done_n = 0; done_first = -1;
        ready_bad = 0; ready_at_done = 1'b0; p_ncs = nCS; p_sclk = SCLK;
    endtask

    task automatic tick_obs(input int n);
        repeat (n) begin
            @(negedge CLK);
            cyc_rel++;
            if (!nCS && p_ncs) begin ncs_fall_n++; ncs_fall_last = cyc_rel; end
            if (nCS && !p_ncs && ncs_rise_first < 0) ncs_rise_first = cyc_rel;
            if (SCLK && !p_sclk) begin
                rise_n++;
                if (first_rise < 0) first_rise = cyc_rel;
                last_rise = cyc_rel;
            end
            if (DONE) begin
                done_n++;
                if (done_first < 0) begin done_first = cyc_rel; ready_at_done = READY; end
            end
            if (cyc_rel >= 1 && cyc_rel <= 198 && READY) ready_bad++;
            p_ncs = nCS; p_sclk = SCLK;
        end
    endtask

    // Called at a falling edge; that cycle becomes relative cycle 0.
    task automatic start_xfer(input logic [15:0] d);
        DATA = d;
        START = 1'b1;
        q.push_back(exp_word(32'(d), 16));
        clr_obs();
    endtask

    int d8;

    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_ready", 32'(READY), 32'd1);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_sclk", 32'(SCLK), 32'd0);
        chk("rst_ncs", 32'(nCS), 32'd1);
        chk("rst_sdata", 32'(SDATA), 32'd0);

        // Reset and START together: reset wins
        START = 1'b1;
        @(negedge CLK);
        chk("rst_start_ready", 32'(READY), 32'd1);
        chk("rst_start_ncs", 32'(nCS), 32'd1);
        START = 1'b0;
        RST = 1'b0;
        @(negedge CLK);

        // 1: basic transfer timing
        start_xfer(16'hA55A);
        tick_obs(1);
        START = 1'b0;
        chk("t1_ncs_c1", 32'(nCS), 32'd0);
        chk("t1_ready_c1", 32'(READY), 32'd0);
        chk("t1_sdata_c1", 32'(SDATA), first_bit(32'hA55A, 16));
        tick_obs(204);
        chk("t1_ncs_fall", 32'(ncs_fall_last), 32'd1);
        chk("t1_first_rise", 32'(first_rise), 32'd7);
        chk("t1_last_rise", 32'(last_rise), 32'd187);
        chk("t1_rise_count", 32'(rise_n), 32'd16);
        chk("t1_ncs_rise", 32'(ncs_rise_first), 32'd193);
        chk("t1_done_cycle", 32'(done_first), 32'd199);
        chk("t1_done_count", 32'(done_n), 32'd1);
        chk("t1_ready_at_done", 32'(ready_at_done), 32'd1);

        // 2: DATA change and START pulse mid-transfer are ignored
        start_xfer(16'hA55A);
        tick_obs(1);
        START = 1'b0;
        tick_obs(49);
        DATA = 16'hFFFF;
        START = 1'b1;
        tick_obs(1);
        START = 1'b0;
        tick_obs(154);
        chk("t2_done_cycle", 32'(done_first), 32'd199);
        chk("t2_done_count", 32'(done_n), 32'd1);
        chk("t2_ready_low", 32'(ready_bad), 32'd0);

        // 3/6: START held high, back-to-back transfers
        start_xfer(16'h0001);
        tick_obs(1);
        chk("t3_sdata_c1", 32'(SDATA), first_bit(32'h0001, 16));
        DATA = 16'h8000;
        q.push_back(exp_word(32'h8000, 16));
        tick_obs(199);
        START = 1'b0;
        chk("t3_done1", 32'(done_first), 32'd199);
        chk("t3_ncs_rise", 32'(ncs_rise_first), 32'd193);
        chk("t3_ncs_refall", 32'(ncs_fall_last), 32'd200);
        chk("t3_ncs_gap", 32'(ncs_fall_last - ncs_rise_first), 32'd7);
        tick_obs(205);
        chk("t3_done_count", 32'(done_n), 32'd2);

        // 4: reset mid-transfer aborts
        start_xfer(16'h1234);
        tick_obs(1);
        START = 1'b0;
        tick_obs(99);
        ma_discard = 1'b1;
        RST = 1'b1;
        tick_obs(1);
        chk("t4_ncs", 32'(nCS), 32'd1);
        chk("t4_sclk", 32'(SCLK), 32'd0);
        chk("t4_sdata", 32'(SDATA), 32'd0);
        chk("t4_ready", 32'(READY), 32'd1);
        RST = 1'b0;
        if (q.size() > 0) q.delete(0);
        tick_obs(120);
        chk("t4_no_done", 32'(done_n), 32'd0);
        start_xfer(16'h5A3C);
        tick_obs(1);
        START = 1'b0;
        tick_obs(204);
        chk("t4_after_done", 32'(done_first), 32'd199);
        chk("t4_after_count", 32'(done_n), 32'd1);

        // 5: DATA_W=8, CLK_DIV=2
        DATA8 = 8'hC3;
        START8 = 1'b1;
        q8.push_back(exp_word(32'hC3, 8));
        d8 = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (k == 1) START8 = 1'b0;
            if (DONE8 && d8 < 0) d8 = k;
        end
        chk("t5_done_cycle", 32'(d8), 32'd35);

        @(negedge CLK);
        chk("sb_drained", 32'(q.size()), 32'd0);
        chk("sb8_drained", 32'(q8.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_tx.md
Name: spi_tx

Overview:
- SPI master transmitter, mode 0 (CPOL=0, CPHA=0), MSB first by default.
- Companion to the team's SPI microphone receiver; drives Pmod DAC-type write-only peripherals (SCLK, nCS, SDATA out).
- Accepts one parallel word per START handshake, serialises it and signals completion.
- Sits between user datapath logic and the Pmod connector, clocked from the system CLK.

Parameters:
- DATA_W, 16, word width in bits; legal range 2..32.
- CLK_DIV, 6, SCLK half-period in CLK cycles; legal values >= 2; elaboration error if smaller.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RST  input  1  synchronous, active-high reset.
- DATA  input  DATA_W  word to send; sampled only when START is accepted.
- START  input  1  request; accepted when START=1 and READY=1 in the same cycle.
- READY  output  1  1 = idle, can accept START.
- DONE  output  1  one-cycle pulse when a transfer completes.
- SCLK  output  1  serial clock to the peripheral.
- nCS  output  1  active-low chip select.
- SDATA  output  1  serial data to the peripheral (MOSI).

Behaviour:
- Reset, synchronous: on the first CLK edge with RST=1 the outputs become READY=1, DONE=0, SCLK=0, nCS=1, SDATA=0. The state, shift register, bit counter and divider counter are cleared.
- States: IDLE, SHIFT, HOLD. Encoding is in the package.
- IDLE:
  - READY=1, nCS=1, SCLK=0, SDATA=0.
  - START accepted at cycle 0: latch DATA into the shift register, clear the divider and bit counter, and go to SHIFT.
- SHIFT:
  - From cycle 1: READY=0, nCS=0, SCLK=0, SDATA = DATA[DATA_W-1].
  - SCLK toggles every CLK_DIV cycles. Rising edges are at cycle 1+(2k+1)*CLK_DIV, for k = 0..DATA_W-1.
  - On each falling edge except the last, shift left so SDATA presents the next bit. The peripheral samples on the rising edge.
  - The final falling edge is at cycle 1+2*DATA_W*CLK_DIV. In that same cycle SCLK=0, nCS=1, SDATA=0, and the block enters HOLD.
- HOLD:
  - nCS stays high for exactly CLK_DIV cycles, giving the minimum deselect time.
  - Then DONE=1 for one cycle and READY=1 in that same cycle, at cycle 1+(2*DATA_W+1)*CLK_DIV. Defaults: cycle 199.
  - The state returns to IDLE in that cycle. START in the DONE cycle is accepted (back-to-back transfers are allowed).
- Boundaries:
  - START while READY=0 is ignored; no queueing.
  - DATA changes after acceptance have no effect on the word in flight.
  - RST mid-transfer: abort. nCS=1 and SCLK=0 on the next edge, no DONE pulse, no partial word completion.
  - RST and START together: reset wins.
  - The bit counter counts 0..DATA_W-1 and never wraps mid-word.
  - The divider counter width is clog2(CLK_DIV). The divider wraps at CLK_DIV-1 and is held at 0 in IDLE.
- No glitches: SCLK, nCS and SDATA are each driven directly from a flop.

Optional Feature:
- Macro: SPI_TX_LSB_FIRST_EN.
- Defined: bit order is LSB first. SDATA starts with DATA[0] and the register shifts right. Timing is identical.
- Undefined: MSB first, as described above.

Decomposition:
- Package spi_pkg holds:
  - the state enum, shared with the receiver's encoding (IDLE, SHIFT, HOLD);
  - default constants SPI_DATA_W=16 and SPI_CLK_DIV=6;
  - a clog2-derived counter-width constant helper.
- Sub-module spi_clk_tick: generates the half-period tick.
  - Inputs: CLK, RST, enable.
  - Output: a one-cycle tick every CLK_DIV cycles while enabled.
  - Reused by the receiver rework.

Test Plan:
1. Reset, then DATA=16'hA55A with a one-cycle START.
   - nCS falls at cycle 1.
   - The sampler captures 16'hA55A on the 16 SCLK rising edges at cycles 7, 19, ..., 187.
   - nCS rises at cycle 193; DONE pulses at cycle 199.
2. After acceptance, DATA changes to 16'hFFFF and START is pulsed mid-transfer.
   - The captured word is still 16'hA55A.
   - Exactly one DONE pulse; READY=0 throughout.
3. START held high continuously with DATA=16'h0001 then 16'h8000.
   - The second transfer is accepted in the DONE cycle, and nCS falls one cycle later.
   - nCS high gap = CLK_DIV+1 = 7 cycles.
   - Words captured: 16'h0001, then 16'h8000.
4. RST asserted at cycle 100 of a transfer.
   - Next cycle: nCS=1, SCLK=0, SDATA=0, READY=1.
   - No DONE pulse.
   - A following START sends a full, correct word.
5. CLK_DIV=2, DATA_W=8, DATA=8'hC3: total latency 1+17*2=35 cycles to DONE; 8'hC3 captured.
6. With SPI_TX_LSB_FIRST_EN defined, DATA=16'h0001: the first SDATA bit is 1 and the captured bit sequence is the reversed word.
